// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and make/break decoder for the Hack computer.
// Produces the 16-bit key code the CPU reads at address 0x6000.
module ps2_keyboard #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        byte_strobe,
    output logic [7:0]  rx_byte,
    output logic        frame_error
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
    typedef enum logic [1:0] {DEC_NORMAL, DEC_EXT, DEC_BRK, DEC_EXT_BRK} decState_t;

    // Two-flop synchronizers for both PS/2 lines
    logic [1:0] clkSync;
    logic [1:0] dataSync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
        end
    end

    // Glitch filter: the clock level flips only after FILTER_LEN differing samples
    logic              filtClk;
    logic [FILT_W-1:0] filtCnt;
    logic              clkDiffers;
    logic              filtFlip;
    logic              fallEdge;
    logic              dataBit;

    assign clkDiffers = (clkSync[1] != filtClk);
    assign filtFlip   = clkDiffers && (filtCnt == FILT_W'(FILTER_LEN - 1));
    assign fallEdge   = filtFlip && filtClk;
    assign dataBit    = dataSync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtClk <= 1'b1;
            filtCnt <= '0;
        end else if (!clkDiffers) begin
            filtCnt <= '0;
        end else if (filtFlip) begin
            filtClk <= ~filtClk;
            filtCnt <= '0;
        end else begin
            filtCnt <= filtCnt + FILT_W'(1);
        end
    end

    // Frame receiver
    rxState_t          rxState, rxStateNext;
    logic [7:0]        shiftReg, shiftNext;
    logic [2:0]        bitCnt, bitCntNext;
    logic              parityOk, parityOkNext;
    logic [TO_W-1:0]   toCnt, toCntNext;
    logic [7:0]        rxByteNext;
    logic              strobeNext;
    logic              errorNext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxState     <= RX_IDLE;
            shiftReg    <= '0;
            bitCnt      <= '0;
            parityOk    <= 1'b0;
            toCnt       <= '0;
            rx_byte     <= '0;
            byte_strobe <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rxState     <= rxStateNext;
            shiftReg    <= shiftNext;
            bitCnt      <= bitCntNext;
            parityOk    <= parityOkNext;
            toCnt       <= toCntNext;
            rx_byte     <= rxByteNext;
            byte_strobe <= strobeNext;
            frame_error <= errorNext;
        end
    end

    always_comb begin
        rxStateNext  = rxState;
        shiftNext    = shiftReg;
        bitCntNext   = bitCnt;
        parityOkNext = parityOk;
        toCntNext    = '0;
        rxByteNext   = rx_byte;
        strobeNext   = 1'b0;
        errorNext    = 1'b0;

        case (rxState)
            RX_IDLE: begin
                if (fallEdge && !dataBit) begin
                    rxStateNext = RX_DATA;
                    bitCntNext  = '0;
                end
            end
            RX_DATA: begin
                if (fallEdge) begin
                    shiftNext  = {dataBit, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        rxStateNext = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fallEdge) begin
                    parityOkNext = ^{shiftReg, dataBit};
                    rxStateNext  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fallEdge) begin
                    if (dataBit && parityOk) begin
                        rxByteNext = shiftReg;
                        strobeNext = 1'b1;
                    end else begin
                        errorNext = 1'b1;
                    end
                    rxStateNext = RX_IDLE;
                end
            end
        endcase

        // Mid-frame watchdog, cleared by every falling edge
        if (rxState != RX_IDLE && !fallEdge) begin
            if (toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                errorNext   = 1'b1;
                rxStateNext = RX_IDLE;
            end else begin
                toCntNext = toCnt + TO_W'(1);
            end
        end
    end

    function automatic logic [7:0] baseMap(input logic [7:0] sc);
        baseMap = 8'd0;
        case (sc)
            8'h1C: baseMap = 8'd65;  8'h32: baseMap = 8'd66;  8'h21: baseMap = 8'd67;
            8'h23: baseMap = 8'd68;  8'h24: baseMap = 8'd69;  8'h2B: baseMap = 8'd70;
            8'h34: baseMap = 8'd71;  8'h33: baseMap = 8'd72;  8'h43: baseMap = 8'd73;
            8'h3B: baseMap = 8'd74;  8'h42: baseMap = 8'd75;  8'h4B: baseMap = 8'd76;
            8'h3A: baseMap = 8'd77;  8'h31: baseMap = 8'd78;  8'h44: baseMap = 8'd79;
            8'h4D: baseMap = 8'd80;  8'h15: baseMap = 8'd81;  8'h2D: baseMap = 8'd82;
            8'h1B: baseMap = 8'd83;  8'h2C: baseMap = 8'd84;  8'h3C: baseMap = 8'd85;
            8'h2A: baseMap = 8'd86;  8'h1D: baseMap = 8'd87;  8'h22: baseMap = 8'd88;
            8'h35: baseMap = 8'd89;  8'h1A: baseMap = 8'd90;
            8'h45: baseMap = 8'd48;  8'h16: baseMap = 8'd49;  8'h1E: baseMap = 8'd50;
            8'h26: baseMap = 8'd51;  8'h25: baseMap = 8'd52;  8'h2E: baseMap = 8'd53;
            8'h36: baseMap = 8'd54;  8'h3D: baseMap = 8'd55;  8'h3E: baseMap = 8'd56;
            8'h46: baseMap = 8'd57;
            8'h29: baseMap = 8'd32;  8'h5A: baseMap = 8'd128; 8'h66: baseMap = 8'd129;
            8'h76: baseMap = 8'd140;
            8'h05: baseMap = 8'd141; 8'h06: baseMap = 8'd142; 8'h04: baseMap = 8'd143;
            8'h0C: baseMap = 8'd144; 8'h03: baseMap = 8'd145; 8'h0B: baseMap = 8'd146;
            8'h83: baseMap = 8'd147; 8'h0A: baseMap = 8'd148; 8'h01: baseMap = 8'd149;
            8'h09: baseMap = 8'd150; 8'h78: baseMap = 8'd151; 8'h07: baseMap = 8'd152;
            8'h0E: baseMap = 8'd96;  8'h4E: baseMap = 8'd45;  8'h55: baseMap = 8'd61;
            8'h54: baseMap = 8'd91;  8'h5B: baseMap = 8'd93;  8'h5D: baseMap = 8'd92;
            8'h4C: baseMap = 8'd59;  8'h52: baseMap = 8'd39;  8'h41: baseMap = 8'd44;
            8'h49: baseMap = 8'd46;  8'h4A: baseMap = 8'd47;
            default: baseMap = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] extMap(input logic [7:0] sc);
        extMap = 8'd0;
        case (sc)
            8'h6B: extMap = 8'd130;  8'h75: extMap = 8'd131;
            8'h74: extMap = 8'd132;  8'h72: extMap = 8'd133;
            8'h6C: extMap = 8'd134;  8'h69: extMap = 8'd135;
            8'h7D: extMap = 8'd136;  8'h7A: extMap = 8'd137;
            8'h70: extMap = 8'd138;  8'h71: extMap = 8'd139;
            default: extMap = 8'd0;
        endcase
    endfunction

    // Make/break decoder; an unmapped code (value 0) never changes the key
    decState_t  decState, decStateNext;
    logic [7:0] keyCode, keyCodeNext;
    logic [7:0] baseCode;
    logic [7:0] extCode;

    assign baseCode = baseMap(rx_byte);
    assign extCode  = extMap(rx_byte);
    assign key      = {8'h00, keyCode};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            decState <= DEC_NORMAL;
            keyCode  <= '0;
        end else begin
            decState <= decStateNext;
            keyCode  <= keyCodeNext;
        end
    end

    always_comb begin
        decStateNext = decState;
        keyCodeNext  = keyCode;
        if (byte_strobe) begin
            case (decState)
                DEC_NORMAL: begin
                    if (rx_byte == 8'hE0) begin
                        decStateNext = DEC_EXT;
                    end else if (rx_byte == 8'hF0) begin
                        decStateNext = DEC_BRK;
                    end else if (baseCode != 8'd0) begin
                        keyCodeNext = baseCode;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        decStateNext = DEC_EXT_BRK;
                    end else begin
                        decStateNext = DEC_NORMAL;
                        if (extCode != 8'd0) begin
                            keyCodeNext = extCode;
                        end
                    end
                end
                DEC_BRK: begin
                    decStateNext = DEC_NORMAL;
                    if (baseCode != 8'd0 && baseCode == keyCode) begin
                        keyCodeNext = '0;
                    end
                end
                DEC_EXT_BRK: begin
                    decStateNext = DEC_NORMAL;
                    if (extCode != 8'd0 && extCode == keyCode) begin
                        keyCodeNext = '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks
// strobes, errors, received bytes and the decoded Hack key code.
module tb_ps2_keyboard;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50000;
    localparam int unsigned HALF_BIT       = 8;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        byte_strobe;
    logic [7:0]  rx_byte;
    logic        frame_error;

    int asserts  = 0;
    int failures = 0;
    int strobeCnt = 0;
    int errCnt    = 0;
    int s0, e0;

    ps2_keyboard #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .byte_strobe(byte_strobe),
        .rx_byte    (rx_byte),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (byte_strobe) strobeCnt <= strobeCnt + 1;
        if (frame_error) errCnt <= errCnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; optional 1-cycle glitches in both the high and the low phase
    task automatic sendBit(input logic b, input bit glitch);
        ps2_data = b;
        tick(HALF_BIT);
        if (glitch) begin
            ps2_clk = 1'b0; tick(1);
            ps2_clk = 1'b1; tick(2);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            tick(3);
            ps2_clk = 1'b1; tick(1);
            ps2_clk = 1'b0;
        end
        tick(HALF_BIT);
        ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit badParity, input bit glitch);
        sendBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) sendBit(b[i], glitch);
        sendBit((~^b) ^ badParity, glitch);
        sendBit(1'b1, glitch);
        ps2_data = 1'b1;
        tick(20);
    endtask

    task automatic send(input logic [7:0] b);
        sendFrame(b, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset_key", key, 16'd0);
        check("reset_rx_byte", 16'(rx_byte), 16'h0);
        check("reset_strobe", 16'(byte_strobe), 16'd0);
        check("reset_error", 16'(frame_error), 16'd0);
        reset = 1'b1;
        tick(5);

        // Make then break of A
        s0 = strobeCnt; e0 = errCnt;
        send(8'h1C);
        check("a_strobe_count", 16'(strobeCnt - s0), 16'd1);
        check("a_rx_byte", 16'(rx_byte), 16'h1C);
        check("a_make_key", key, 16'd65);
        check("a_no_error", 16'(errCnt - e0), 16'd0);
        send(8'hF0); send(8'h1C);
        check("a_break_key", key, 16'd0);

        // Last pressed wins; break of an older key is ignored
        send(8'h1C);
        check("a_again", key, 16'd65);
        send(8'h29);
        check("space_make", key, 16'd32);
        send(8'hF0); send(8'h1C);
        check("a_break_ignored", key, 16'd32);
        send(8'hF0); send(8'h29);
        check("space_break", key, 16'd0);

        // Extended arrow, its break, and the unmapped keypad code
        send(8'hE0); send(8'h6B);
        check("left_make", key, 16'd130);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("left_break", key, 16'd0);
        send(8'h1C);
        send(8'h6B);
        check("kp4_unmapped", key, 16'd65);
        send(8'h12);
        check("shift_unmapped", key, 16'd65);
        send(8'h1C);
        check("typematic", key, 16'd65);

        // Parity error then a good enter
        s0 = strobeCnt; e0 = errCnt;
        sendFrame(8'h5A, 1'b1, 1'b0);
        check("parity_error", 16'(errCnt - e0), 16'd1);
        check("parity_no_strobe", 16'(strobeCnt - s0), 16'd0);
        check("parity_key_kept", key, 16'd65);
        send(8'h5A);
        check("enter_make", key, 16'd128);
        check("enter_rx_byte", 16'(rx_byte), 16'h5A);

        // Timeout after start bit and three data bits
        s0 = strobeCnt; e0 = errCnt;
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        ps2_data = 1'b1;
        tick(TIMEOUT_CYCLES - 100);
        check("timeout_not_early", 16'(errCnt - e0), 16'd0);
        tick(200);
        check("timeout_error", 16'(errCnt - e0), 16'd1);
        check("timeout_no_strobe", 16'(strobeCnt - s0), 16'd0);
        send(8'h76);
        check("esc_make", key, 16'd140);
        check("esc_rx_byte", 16'(rx_byte), 16'h76);

        // Glitches shorter than the filter length
        s0 = strobeCnt; e0 = errCnt;
        sendFrame(8'h66, 1'b0, 1'b1);
        check("glitch_strobe_count", 16'(strobeCnt - s0), 16'd1);
        check("glitch_no_error", 16'(errCnt - e0), 16'd0);
        check("glitch_rx_byte", 16'(rx_byte), 16'h66);
        check("backspace_make", key, 16'd129);

        // Reset mid-frame clears immediately and discards the partial frame
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("midreset_key", key, 16'd0);
        check("midreset_rx_byte", 16'(rx_byte), 16'h0);
        tick(3);
        reset = 1'b1;
        ps2_data = 1'b1;
        tick(10);
        s0 = strobeCnt; e0 = errCnt;
        send(8'h1C);
        check("post_reset_key", key, 16'd65);
        check("post_reset_strobe", 16'(strobeCnt - s0), 16'd1);
        check("post_reset_no_error", 16'(errCnt - e0), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Memory-mapped keyboard source for the Hack computer. Receives PS/2 set-2 scancode frames from a physical keyboard and decodes make/break sequences into a Hack key code.
- Drives the 16-bit value the computer returns for reads of address 0x6000 (the scancode register feeding the CPU input mux).
- Output holds the code of the currently pressed key, or 0 when no key is held.

Parameters:
- FILTER_LEN, 4, number of consecutive identical synchronized samples required before a ps2_clk level change is accepted.
- TIMEOUT_CYCLES, 50000, system-clock cycles without a ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the device; asynchronous to clock.
- ps2_data  input  1  raw PS/2 data; asynchronous to clock.
- key  output  16  current Hack key code; 0 means no key held.
- byte_strobe  output  1  one-cycle pulse when a frame with valid parity and stop bit has been received.
- rx_byte  output  8  last valid received byte; updated with byte_strobe.
- frame_error  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - key=0, rx_byte=0, byte_strobe=0, frame_error=0.
  - Receiver in IDLE, decoder in NORMAL, synchronizers and filter preset to 1, timeout counter cleared.
  - Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The clock line then passes through the FILTER_LEN glitch filter.
  - A falling edge is filtered clock going 1->0. Data is sampled on that edge.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: a falling edge with data=0 (start bit) moves to DATA and clears the bit counter. A falling edge with data=1 stays in IDLE with no error.
  - DATA: 8 bits, LSB first, shifted on each falling edge. After the 8th bit, move to PARITY.
  - PARITY: the sampled bit must make the 9-bit total (data + parity) odd; record pass/fail. Move to STOP.
  - STOP: sampled bit must be 1. If the stop bit and parity are good: rx_byte updates and byte_strobe pulses 1 cycle after the stop-bit edge. Otherwise frame_error pulses and no byte is delivered. Return to IDLE.
  - Timeout: in DATA/PARITY/STOP, TIMEOUT_CYCLES consecutive cycles without a falling edge -> frame_error pulse, IDLE. The counter resets on every falling edge.
- Decoder FSM (advances only on byte_strobe): NORMAL, EXT, BRK, EXT_BRK.
  - NORMAL: 0xE0 -> EXT; 0xF0 -> BRK; otherwise make code, lookup in the base table.
  - EXT: 0xF0 -> EXT_BRK; otherwise extended make code, lookup in the extended table, -> NORMAL.
  - BRK / EXT_BRK: the byte is a break code, lookup in the base or extended table respectively, -> NORMAL.
  - Make with a mapped code: key updates to that code (last pressed wins). Typematic repeats rewrite the same value.
  - Break: key clears to 0 only if its mapped code equals the current key. Otherwise key is unchanged.
  - Unmapped codes (including shift 0x12/0x59, ctrl, alt, 0xE1 sequences, 0xAA BAT, 0xFA ACK) leave key unchanged. The FSM still returns to NORMAL.
  - key updates 1 cycle after byte_strobe, i.e. 2 cycles after the final stop-bit edge.
- Base table (Hack character set):
  - Letters map to uppercase ASCII 65-90.
  - Digits map to 48-57.
  - 0x29 space -> 32, 0x5A enter -> 128, 0x66 backspace -> 129, 0x76 esc -> 140.
  - F1-F12 -> 141-152.
  - Punctuation keys map to unshifted ASCII.
- Extended table (after 0xE0):
  - 0x6B left -> 130, 0x75 up -> 131, 0x74 right -> 132, 0x72 down -> 133.
  - 0x6C home -> 134, 0x69 end -> 135, 0x7D pgup -> 136, 0x7A pgdn -> 137.
  - 0x70 insert -> 138, 0x71 delete -> 139.
- key bits 15:8 are always 0.

Test Plan:
- Reset, then frame 0x1C (parity 0) -> byte_strobe once, rx_byte=0x1C, key=65; then F0,1C -> key=0.
- Make 0x1C, make 0x29, break 0x1C -> key=65, then 32, stays 32 after break of A; break 0x29 -> 0.
- Sequence E0,6B -> key=130; E0,F0,6B -> key=0. Bare 0x6B (keypad 4) is unmapped -> key unchanged.
- Frame 0x5A with wrong parity bit -> frame_error pulse, no byte_strobe, key unchanged; next good 0x5A -> key=128.
- Start bit plus 3 data bits, then ps2_clk idle TIMEOUT_CYCLES -> frame_error pulse, receiver IDLE; next full frame 0x76 -> key=140.
- 1-cycle glitches on ps2_clk shorter than FILTER_LEN during a frame -> no extra bits, byte 0x66 received, key=129. Reset pulse mid-frame -> key=0 immediately, following frame decoded correctly.
